// File: rtl/aes_defs.sv
// Shared AES-128/192/256 constants and sequencer state encoding.
package aes_defs;

  localparam int AES_BLK_W  = 128;
  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDK  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_t;

endpackage

// File: rtl/aes_round_seq.sv
// Iterative AES encryption sequencer: state register, round counter,
// round-key fetch and AddRoundKey around an external round datapath.
module aes_round_seq
  import aes_defs::*;
#(
  parameter int NR    = AES_NR_128,
  parameter int BLK_W = AES_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_block,
  output logic             rk_req,
  output logic [3:0]       rk_idx,
  input  logic             rk_valid,
  input  logic [BLK_W-1:0] rk_data,
  output logic [BLK_W-1:0] rnd_state,
  output logic             rnd_mix_en,
  input  logic [BLK_W-1:0] rnd_result,
  output logic             busy
);

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t             fsm_q, fsm_d;
  logic [BLK_W-1:0] state_q, state_d;
  logic [3:0]       round_q, round_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Outputs depend on fsm_q/round_q only; inputs only steer next state.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    round_d    = round_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rk_req     = 1'b0;
    rk_idx     = 4'd0;
    rnd_mix_en = 1'b0;
    busy       = 1'b1;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = in_block;
          round_d = 4'd0;
          fsm_d   = ADDK;
        end
      end
      ADDK: begin
        rk_req = 1'b1;
        if (rk_valid) begin
          state_d = state_q ^ rk_data;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_req     = 1'b1;
        rk_idx     = round_q;
        rnd_mix_en = (round_q != LAST);
        if (rk_valid) begin
          state_d = rnd_result ^ rk_data;
          if (round_q == LAST) fsm_d = DONE;
          else round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
    endcase
  end

  assign out_block = state_q;
  assign rnd_state = state_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq with a behavioural round datapath
// and key schedule standing in for the cipher-top siblings.
module tb_aes_round_seq;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid = 1'b0;
  logic [127:0] rk_data;
  logic [127:0] rnd_state;
  logic         rnd_mix_en;
  logic [127:0] rnd_result;
  logic         busy;

  aes_round_seq #(.NR(NR), .BLK_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_data(rk_data), .rnd_state(rnd_state),
    .rnd_mix_en(rnd_mix_en), .rnd_result(rnd_result), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a);
    return {a[6:0], a[7]};
  endfunction

  function automatic logic [127:0] round_model(input logic [127:0] s,
                                               input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++) t[q+4*c] = b[q+4*((c+q)%4)];
    if (mix)
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  assign rnd_result = round_model(rnd_state, rnd_mix_en);
  assign rk_data    = rk[rk_idx];

  // 0: rk_valid low, 1: tied high, 2: random ~30% duty
  int rk_mode = 0;
  always @(negedge clk) begin
    if (rk_mode == 1) rk_valid = 1'b1;
    else if (rk_mode == 2) rk_valid = ($urandom_range(0, 99) < 30);
    else rk_valid = 1'b0;
  end

  logic         mon_en = 1'b0;
  int           cyc_cnt = 0;
  logic [3:0]   idx_q [$];
  int           acc_q [$];
  logic [127:0] ct_q  [$];
  logic         had_stall = 1'b0;
  logic [3:0]   stall_idx = 4'd0;
  int           stall_err = 0;
  int           mix0 = 0;
  int           mix1 = 0;
  int           mixbad = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (!mon_en) begin
      idx_q.delete();
      acc_q.delete();
      ct_q.delete();
      had_stall <= 1'b0;
      stall_err <= 0;
      mix0      <= 0;
      mix1      <= 0;
      mixbad    <= 0;
    end else begin
      if (rk_req && rk_valid) idx_q.push_back(rk_idx);
      if (had_stall && !(rk_req && rk_idx == stall_idx))
        stall_err <= stall_err + 1;
      had_stall <= rk_req && !rk_valid;
      stall_idx <= rk_idx;
      if (rk_req && rk_idx != 4'd0 && !rnd_mix_en) mix0 <= mix0 + 1;
      if (rnd_mix_en) begin
        mix1 <= mix1 + 1;
        if (!(rk_req && rk_idx >= 4'd1 && rk_idx <= 4'(NR - 1)))
          mixbad <= mixbad + 1;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc_cnt);
      if (out_valid && out_ready) ct_q.push_back(out_block);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_tables(input logic [127:0] key);
    logic [7:0]  p, rcon;
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int a = 0; a < 256; a++) begin
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, 8'(a));
      sbox[a] = p ^ rl(p) ^ rl(rl(p)) ^ rl(rl(rl(p))) ^
                rl(rl(rl(rl(p)))) ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]],
               sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) rk[j] = '0;
    for (int j = 0; j <= NR; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic send(input logic [127:0] pt, output int cyc,
                      output logic [127:0] ct);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_block = pt;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    ct = out_block;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

  initial begin
    int           cyc, k;
    logic [127:0] ct;
    logic         ok, found;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b0;
    build_tables(KEY);
    repeat (3) @(negedge clk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_outs", {out_valid, rk_req, rnd_mix_en, busy, rk_idx}, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_rnd_state", rnd_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // FIPS-197 App.B, rk_valid tied high, then a 20-cycle output stall
    rk_mode = 1;
    mon_en  = 1'b1;
    send(PT0, cyc, ct);
    chk("t1_latency", cyc, NR + 2);
    chk("t1_ct", ct, CT0);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t3_mix_off_cycles", mix0, 1);
    chk("t3_mix_on_cycles", mix1, NR - 1);
    chk("t3_mix_bad", mixbad, 0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_block === CT0 &&
            in_ready === 1'b0 && busy === 1'b1)) ok = 1'b0;
    end
    chk("t4_hold", ok, 1);
    drain();
    chk("t4_release_ready", {in_ready, out_valid, busy}, 3'b100);
    mon_en = 1'b0;
    @(negedge clk);

    // random rk_valid stalls
    mon_en  = 1'b1;
    rk_mode = 2;
    send(PT0, cyc, ct);
    chk("t2_ct", ct, CT0);
    chk("t2_idx_count", idx_q.size(), NR + 1);
    ok = (idx_q.size() == NR + 1);
    for (int i = 0; i < idx_q.size() && i <= NR; i++)
      if (idx_q[i] !== 4'(i)) ok = 1'b0;
    chk("t2_idx_seq", ok, 1);
    chk("t2_stall_stable", stall_err, 0);
    drain();
    chk("t2_idle", in_ready, 1);
    mon_en  = 1'b0;
    rk_mode = 1;
    @(negedge clk);

    // back-to-back blocks
    mon_en    = 1'b1;
    in_block  = PT1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    k = 0;
    while (acc_q.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    in_block = PT2;
    while (ct_q.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_count", ct_q.size(), 2);
    if (ct_q.size() >= 2 && acc_q.size() >= 2) begin
      chk("t5_ct0", ct_q[0], CT1);
      chk("t5_ct1", ct_q[1], CT2);
      chk("t5_spacing", acc_q[1] - acc_q[0], NR + 3);
    end
    mon_en = 1'b0;
    @(negedge clk);
    chk("t5_idle", {in_ready, busy}, 2'b10);

    // reset during round 5
    in_block = PT0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      if (rk_req === 1'b1 && rk_idx === 4'd5) found = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk("t6_reach_r5", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_after_rst", {busy, out_valid, in_ready, rk_req}, 4'b0010);
    chk("t6_state_clr", rnd_state, 0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("t6_discarded", ok, 1);
    send(PT1, cyc, ct);
    chk("t6_latency", cyc, NR + 2);
    chk("t6_ct", ct, CT1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
